eth_tx_arbiter: RTL



---
 rtl/eth_tx_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
//   Round-robin arbiter sharing one RMII transmit dibit stream between
//   NUM_SRC frame producers. Each frame: 31 preamble dibits (01) and the SFD
//   dibit (11), then the granted source's dibits, then IPG_DIBITS idle cycles.
//   A granted source that never presents a valid dibit within START_TIMEOUT
//   DATA cycles loses its grant and err_timeout pulses for one cycle.
//
// Ports
//   clk         50 MHz RMII-domain clock
//   rst         asynchronous, active-high reset
//   req         per-source frame request (level, sampled only in IDLE)
//   src_axiiv   per-source dibit valid
//   src_axiid   per-source dibit, source i on bits [2i+1:2i]
//   gnt         one-hot grant, high while the source owns the stream
//   axiov       output dibit valid (registered)
//   axiod       output dibit (registered)
//   busy        high whenever the arbiter is not idle (registered)
//   err_timeout one-cycle pulse when a grant is aborted by timeout
module eth_tx_arbiter #(
  parameter int NUM_SRC       = 2,
  parameter int IPG_DIBITS    = 48,
  parameter int START_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [NUM_SRC-1:0]     src_axiiv,
  input  logic [2*NUM_SRC-1:0]   src_axiid,
  output logic [NUM_SRC-1:0]     gnt,
  output logic                   axiov,
  output logic [1:0]             axiod,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int PRE_LEN = 32;
  localparam int CNT_MAX_A = (IPG_DIBITS > PRE_LEN) ? IPG_DIBITS : PRE_LEN;
  localparam int CNT_MAX   = (START_TIMEOUT > CNT_MAX_A) ? START_TIMEOUT : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_GAP
  } state_t;

  state_t             r_state, w_state;
  logic [SEL_W-1:0]   r_sel, w_sel;
  logic [SEL_W-1:0]   r_ptr, w_ptr;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic               r_seen, w_seen;
  logic [NUM_SRC-1:0] r_gnt, w_gnt;
  logic               r_axiov, w_axiov;
  logic [1:0]         r_axiod, w_axiod;
  logic               r_busy, w_busy;
  logic               r_err, w_err;

  logic [SEL_W-1:0]   w_pick, w_lo, w_hi;
  logic               w_lo_found, w_hi_found;
  logic               w_sv;
  logic [1:0]         w_sd;
  logic [SEL_W-1:0]   w_ptr_next;

  // Round-robin pick: lowest requester at/after the pointer, else wrap to the
  // lowest requester overall.
  always_comb begin
    w_lo       = '0;
    w_hi       = '0;
    w_lo_found = 1'b0;
    w_hi_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !w_lo_found) begin
        w_lo       = SEL_W'(i);
        w_lo_found = 1'b1;
      end
      if (req[i] && !w_hi_found && (SEL_W'(i) >= r_ptr)) begin
        w_hi       = SEL_W'(i);
        w_hi_found = 1'b1;
      end
    end
    w_pick = w_hi_found ? w_hi : w_lo;
  end

  assign w_sv       = src_axiiv[r_sel];
  assign w_sd       = src_axiid[{r_sel, 1'b0} +: 2];
  assign w_ptr_next = (r_sel == SEL_W'(NUM_SRC - 1)) ? '0 : r_sel + 1'b1;

  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_ptr   = r_ptr;
    w_cnt   = r_cnt;
    w_seen  = r_seen;
    w_gnt   = r_gnt;
    w_axiov = 1'b0;
    w_axiod = 2'b00;
    w_err   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_sel   = w_pick;
          w_cnt   = '0;
          w_state = S_PRE;
        end
      end

      S_PRE: begin
        w_axiov = 1'b1;
        if (r_cnt == CNT_W'(PRE_LEN - 1)) begin
          w_axiod = 2'b11;
          w_gnt   = '0;
          w_gnt[r_sel] = 1'b1;
          w_cnt   = '0;
          w_seen  = 1'b0;
          w_state = S_DATA;
        end else begin
          w_axiod = 2'b01;
          w_cnt   = r_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (r_seen && !w_sv) begin
          w_gnt   = '0;
          w_cnt   = '0;
          w_ptr   = w_ptr_next;
          w_state = S_GAP;
        end else if (!r_seen && !w_sv && (r_cnt == CNT_W'(START_TIMEOUT - 1))) begin
          w_gnt   = '0;
          w_err   = 1'b1;
          w_cnt   = '0;
          w_ptr   = w_ptr_next;
          w_state = S_GAP;
        end else begin
          w_axiov = w_sv;
          w_axiod = w_sd;
          if (w_sv) begin
            w_seen = 1'b1;
          end
          // cnt only measures the wait for the first valid dibit
          if (!r_seen) begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end

      S_GAP: begin
        if (r_cnt == CNT_W'(IPG_DIBITS - 1)) begin
          w_cnt   = '0;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_seen  <= 1'b0;
      r_gnt   <= '0;
      r_axiov <= 1'b0;
      r_axiod <= 2'b00;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
      r_seen  <= w_seen;
      r_gnt   <= w_gnt;
      r_axiov <= w_axiov;
      r_axiod <= w_axiod;
      r_busy  <= w_busy;
      r_err   <= w_err;
    end
  end

  assign gnt         = r_gnt;
  assign axiov       = r_axiov;
  assign axiod       = r_axiod;
  assign busy        = r_busy;
  assign err_timeout = r_err;

endmodule
